// File: rtl/mem_wb_stage.sv
// M stage of the pipeline: performs the data-memory access over a req/gnt/rvalid
// handshake, formats store lanes and load data, and registers the MEM/WB bundle.
module mem_wb_stage #(
    parameter int word_width = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWriteM,
    input  logic [1:0]            ResultSrcM,
    input  logic                  MemWriteM,
    input  logic [2:0]            funct3M,
    input  logic [word_width-1:0] ALUResultM,
    input  logic [word_width-1:0] WriteDataM,
    input  logic [4:0]            RdM,
    input  logic [word_width-1:0] PCPlus4M,
    output logic                  StallM,
    output logic                  access_err,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [word_width-1:0] dmem_addr,
    output logic [word_width-1:0] dmem_wdata,
    output logic [3:0]            dmem_be,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [word_width-1:0] dmem_rdata,
    output logic                  RegWriteW,
    output logic [1:0]            ResultSrcW,
    output logic [word_width-1:0] ReadDataW,
    output logic [word_width-1:0] ALUResultW,
    output logic [4:0]            RdW,
    output logic [word_width-1:0] PCPlus4W
);

    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] WAIT_RESP = 1'b1;

    logic [0:0] state_r;
    logic [0:0] next_state_s;
    logic       is_store_s;
    logic       is_load_s;
    logic       access_s;
    logic       f3_ok_s;
    logic       aligned_s;
    logic       legal_s;
    logic [1:0] addr_lo_s;

    // Select the addressed byte/halfword (little-endian) and sign/zero extend it.
    function automatic logic [31:0] load_extend(input logic [2:0] f3,
                                                input logic [1:0] lo,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  load_extend = {{24{b[7]}}, b};
            3'b001:  load_extend = {{16{h[15]}}, h};
            3'b100:  load_extend = {24'h000000, b};
            3'b101:  load_extend = {16'h0000, h};
            default: load_extend = word;
        endcase
    endfunction

    // Classify the M-stage instruction; a store wins over a load-marked result select.
    always_comb begin
        addr_lo_s  = ALUResultM[1:0];
        is_store_s = MemWriteM;
        is_load_s  = !MemWriteM && (ResultSrcM == 2'b01);
        access_s   = is_store_s || is_load_s;
        case (funct3M)
            3'b000:  f3_ok_s = 1'b1;
            3'b001:  f3_ok_s = 1'b1;
            3'b010:  f3_ok_s = 1'b1;
            3'b100:  f3_ok_s = is_load_s;
            3'b101:  f3_ok_s = is_load_s;
            default: f3_ok_s = 1'b0;
        endcase
        case (funct3M[1:0])
            2'b01:   aligned_s = !addr_lo_s[0];
            2'b10:   aligned_s = (addr_lo_s == 2'b00);
            default: aligned_s = 1'b1;
        endcase
        legal_s = access_s && f3_ok_s && aligned_s;
    end

    // Memory address, write enable and lane-replicated store data.
    always_comb begin
        dmem_addr  = {word_width{1'b0}};
        dmem_we    = 1'b0;
        dmem_be    = 4'b0000;
        dmem_wdata = {word_width{1'b0}};
        if (access_s) begin
            dmem_addr = {ALUResultM[word_width-1:2], 2'b00};
            dmem_we   = is_store_s;
            if (is_store_s) begin
                case (funct3M[1:0])
                    2'b00: begin
                        dmem_be    = 4'b0001 << addr_lo_s;
                        dmem_wdata = {4{WriteDataM[7:0]}};
                    end
                    2'b01: begin
                        dmem_be    = 4'b0011 << {addr_lo_s[1], 1'b0};
                        dmem_wdata = {2{WriteDataM[15:0]}};
                    end
                    default: begin
                        dmem_be    = 4'b1111;
                        dmem_wdata = WriteDataM;
                    end
                endcase
            end else begin
                dmem_be    = 4'b1111;
                dmem_wdata = {word_width{1'b0}};
            end
        end else begin
            dmem_addr = {word_width{1'b0}};
        end
    end

    // Handshake control: request, stall, error pulse and next state.
    always_comb begin
        dmem_req     = 1'b0;
        StallM       = 1'b0;
        access_err   = 1'b0;
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                dmem_req   = legal_s;
                access_err = access_s && !legal_s;
                StallM     = legal_s && (is_load_s || !dmem_gnt);
                if (legal_s && is_load_s && dmem_gnt) begin
                    next_state_s = WAIT_RESP;
                end else begin
                    next_state_s = IDLE;
                end
            end
            WAIT_RESP: begin
                StallM = !dmem_rvalid;
                if (dmem_rvalid) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = WAIT_RESP;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // FSM state and MEM/WB register; a stalled cycle injects a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            ReadDataW  <= {word_width{1'b0}};
            ALUResultW <= {word_width{1'b0}};
            RdW        <= 5'd0;
            PCPlus4W   <= {word_width{1'b0}};
        end else begin
            state_r <= next_state_s;
            if (!StallM) begin
                RegWriteW  <= RegWriteM && !access_err;
                ResultSrcW <= ResultSrcM;
                ReadDataW  <= (state_r == WAIT_RESP) ?
                              load_extend(funct3M, addr_lo_s, dmem_rdata) : {word_width{1'b0}};
                ALUResultW <= ALUResultM;
                RdW        <= RdM;
                PCPlus4W   <= PCPlus4M;
            end else begin
                RegWriteW <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized self-checking bench for mem_wb_stage with a transaction-level model
// of the access rules and a small memory responder with random latencies.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic        StallM, access_err, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ReadDataW, ALUResultW, PCPlus4W;
    logic [4:0]  RdW;

    int n_checks = 0;
    int n_fail   = 0;

    // expected MEM/WB contents
    logic        e_rw;
    logic [1:0]  e_rs;
    logic [31:0] e_rdata, e_alu, e_pc;
    logic [4:0]  e_rd;

    always #5 clk = ~clk;

    mem_wb_stage #(.word_width(32)) dut (
        .clk(clk), .reset(reset),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .funct3M(funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .RdM(RdM), .PCPlus4M(PCPlus4M),
        .StallM(StallM), .access_err(access_err),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ReadDataW(ReadDataW),
        .ALUResultW(ALUResultW), .RdW(RdW), .PCPlus4W(PCPlus4W)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_w();
        chk("RegWriteW",  32'(RegWriteW),  32'(e_rw));
        chk("ResultSrcW", 32'(ResultSrcW), 32'(e_rs));
        chk("ReadDataW",  ReadDataW,       e_rdata);
        chk("ALUResultW", ALUResultW,      e_alu);
        chk("RdW",        32'(RdW),        32'(e_rd));
        chk("PCPlus4W",   PCPlus4W,        e_pc);
    endtask

    task automatic complete_model(input logic rw, input logic [1:0] rs, input logic [31:0] rdv,
                                  input logic [31:0] addr, input logic [4:0] rd, input logic [31:0] pc4);
        e_rw = rw; e_rs = rs; e_rdata = rdv; e_alu = addr; e_rd = rd; e_pc = pc4;
    endtask

    // Runs one M-stage instruction to completion; called at posedge+1.
    task automatic run_instr(input logic rw, input logic [1:0] rs, input logic mw,
                             input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [4:0] rd, input logic [31:0] pc4,
                             input int gdly, input int rdly, input logic [31:0] rdata);
        logic st, ld, acc, legal, lg;
        logic [3:0]  xbe;
        logic [31:0] xwd, xrd, bytev, halfv, shifted;
        int lo;
        st  = mw;
        ld  = !mw && (rs == 2'b01);
        acc = st || ld;
        lo  = int'(addr % 32'd4);
        if (st)      legal = (f3 == 3'd0) || (f3 == 3'd1 && lo % 2 == 0) || (f3 == 3'd2 && lo == 0);
        else if (ld) legal = (f3 == 3'd0 || f3 == 3'd4) || ((f3 == 3'd1 || f3 == 3'd5) && lo % 2 == 0)
                             || (f3 == 3'd2 && lo == 0);
        else         legal = 1'b0;
        xbe = 4'hF; xwd = 32'h0;
        if (st && f3 == 3'd0) begin xbe = 4'(1 << lo); xwd = (wd & 32'hFF) * 32'h01010101; end
        if (st && f3 == 3'd1) begin xbe = 4'(3 << lo); xwd = (wd & 32'hFFFF) * 32'h00010001; end
        if (st && f3 == 3'd2) xwd = wd;
        shifted = rdata >> (8 * lo);
        bytev = shifted & 32'hFF;
        halfv = shifted & 32'hFFFF;
        case (f3)
            3'd0:    xrd = (bytev >= 32'd128)   ? (bytev | 32'hFFFFFF00) : bytev;
            3'd1:    xrd = (halfv >= 32'd32768) ? (halfv | 32'hFFFF0000) : halfv;
            3'd4:    xrd = bytev;
            3'd5:    xrd = halfv;
            default: xrd = rdata;
        endcase
        RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw; funct3M = f3;
        ALUResultM = addr; WriteDataM = wd; RdM = rd; PCPlus4M = pc4;
        if (!legal) begin
            dmem_gnt = 1'b0; dmem_rvalid = ($urandom % 4 == 0); dmem_rdata = $urandom;
            #1;
            chk("stall_nolegal", 32'(StallM), 32'd0);
            chk("req_nolegal",   32'(dmem_req), 32'd0);
            chk("access_err",    32'(access_err), 32'(acc));
            if (!acc) begin
                chk("idle_be",    32'(dmem_be), 32'd0);
                chk("idle_wdata", dmem_wdata, 32'd0);
                chk("idle_addr",  dmem_addr, 32'd0);
            end
            @(posedge clk);
            complete_model(acc ? 1'b0 : rw, rs, 32'h0, addr, rd, pc4);
            #1 check_w();
        end else begin
            for (int w = 0; w <= gdly; w++) begin
                lg = (w == gdly);
                dmem_gnt = lg; dmem_rvalid = st && ($urandom % 4 == 0); dmem_rdata = $urandom;
                #1;
                chk("req",    32'(dmem_req), 32'd1);
                chk("err",    32'(access_err), 32'd0);
                chk("we",     32'(dmem_we), 32'(st));
                chk("addr",   dmem_addr, addr & 32'hFFFFFFFC);
                chk("be",     32'(dmem_be), 32'(xbe));
                chk("wdata",  dmem_wdata, xwd);
                chk("stall_req", 32'(StallM), 32'(ld || !lg));
                @(posedge clk);
                if (st && lg) complete_model(rw, rs, 32'h0, addr, rd, pc4);
                else e_rw = 1'b0;
                #1 check_w();
            end
            if (ld) begin
                for (int k = 1; k <= rdly; k++) begin
                    dmem_gnt = 1'b0; dmem_rvalid = (k == rdly);
                    dmem_rdata = (k == rdly) ? rdata : $urandom;
                    #1;
                    chk("req_wait",   32'(dmem_req), 32'd0);
                    chk("stall_wait", 32'(StallM), 32'(k != rdly));
                    @(posedge clk);
                    if (k == rdly) complete_model(rw, rs, xrd, addr, rd, pc4);
                    else e_rw = 1'b0;
                    #1 check_w();
                end
            end
        end
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    endtask

    initial begin
        logic [2:0] f3s [8];
        f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd2, 3'd1};
        reset = 1'b1;
        RegWriteM = 1'b1; ResultSrcM = 2'b00; MemWriteM = 1'b0; funct3M = 3'd0;
        ALUResultM = 32'h55; WriteDataM = 32'h0; RdM = 5'd3; PCPlus4M = 32'h4;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        complete_model(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 32'h0);
        check_w();
        reset = 1'b0;

        // ADD passes through with one-cycle latency
        run_instr(1'b1, 2'b00, 1'b0, 3'd0, 32'h1234, 32'h0, 5'd5, 32'h8, 0, 0, 32'h0);
        chk("add_rw_lit",  32'(RegWriteW), 32'd1);
        chk("add_alu_lit", ALUResultW, 32'h1234);
        chk("add_rd_lit",  32'(RdW), 32'd5);

        // SB 0x103 with two wait cycles before gnt
        RegWriteM = 1'b0; ResultSrcM = 2'b00; MemWriteM = 1'b1; funct3M = 3'd0;
        ALUResultM = 32'h103; WriteDataM = 32'h123456AB; RdM = 5'd0; PCPlus4M = 32'hC;
        for (int c = 0; c < 3; c++) begin
            dmem_gnt = (c == 2);
            #1;
            chk("sb_be_lit",    32'(dmem_be), 32'h8);
            chk("sb_wdata_lit", dmem_wdata, 32'hABABABAB);
            chk("sb_stall",     32'(StallM), (c == 2) ? 32'd0 : 32'd1);
            @(posedge clk);
            #1 chk("sb_rw", 32'(RegWriteW), 32'd0);
        end
        dmem_gnt = 1'b0;
        complete_model(1'b0, 2'b00, 32'h0, 32'h103, 5'd0, 32'hC);

        // LB / LBU / LH against a fixed word
        run_instr(1'b1, 2'b01, 1'b0, 3'd0, 32'h101, 32'h0, 5'd7, 32'h10, 0, 3, 32'h0080FF00);
        chk("lb_lit", ReadDataW, 32'hFFFFFFFF);
        run_instr(1'b1, 2'b01, 1'b0, 3'd4, 32'h101, 32'h0, 5'd7, 32'h14, 0, 3, 32'h0080FF00);
        chk("lbu_lit", ReadDataW, 32'h000000FF);
        run_instr(1'b1, 2'b01, 1'b0, 3'd1, 32'h102, 32'h0, 5'd7, 32'h18, 1, 2, 32'h0080FF00);
        chk("lh_lit", ReadDataW, 32'h00000080);

        // misaligned LW is a bubble with an error pulse
        run_instr(1'b1, 2'b01, 1'b0, 3'd2, 32'h102, 32'h0, 5'd9, 32'h1C, 0, 1, 32'h0);
        chk("lw_mis_rw_lit", 32'(RegWriteW), 32'd0);

        // reset while waiting for a response; late rvalid must be ignored
        RegWriteM = 1'b1; ResultSrcM = 2'b01; MemWriteM = 1'b0; funct3M = 3'd2;
        ALUResultM = 32'h100; RdM = 5'd4; PCPlus4M = 32'h20; dmem_gnt = 1'b1;
        @(posedge clk);
        #1 dmem_gnt = 1'b0; reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        RegWriteM = 1'b0; ResultSrcM = 2'b00; MemWriteM = 1'b0; funct3M = 3'd0;
        ALUResultM = 32'h0; WriteDataM = 32'h0; RdM = 5'd0; PCPlus4M = 32'h0;
        chk("rst_rw",   32'(RegWriteW), 32'd0);
        chk("rst_alu",  ALUResultW, 32'h0);
        @(posedge clk);
        #1 dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
        #1 chk("rst_late_stall", 32'(StallM), 32'd0);
        chk("rst_late_req", 32'(dmem_req), 32'd0);
        @(posedge clk);
        #1 dmem_rvalid = 1'b0;
        chk("rst_late_rw",   32'(RegWriteW), 32'd0);
        chk("rst_late_data", ReadDataW, 32'h0);
        complete_model(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 32'h0);

        // randomized traffic, back to back
        for (int i = 0; i < 400; i++) begin
            logic [2:0] f3;
            logic mw;
            logic [1:0] rs;
            f3 = ($urandom % 5 == 0) ? 3'($urandom) : f3s[$urandom % 8];
            mw = ($urandom % 3 == 0);
            rs = ($urandom % 2 == 0) ? 2'b01 : 2'($urandom);
            run_instr(1'($urandom), rs, mw, f3, $urandom, $urandom, 5'($urandom), $urandom,
                      int'($urandom % 4), 1 + int'($urandom % 4), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Consumer end of the EX/MEM pipeline register: takes the M-stage control/data bundle and performs the data-memory access through a req/gnt/rvalid handshake.
- Formats store byte-lanes and load data (sign/zero extension), and stalls the pipeline while an access is outstanding.
- Registers the completed instruction into the MEM/WB bundle consumed by writeback.

Parameters:
word_width, 32, datapath width; byte-lane logic is defined for 32 only.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
RegWriteM  input  1  register-file write enable of M-stage instruction
ResultSrcM  input  2  result select: 00 ALU, 01 memory, 10 PC+4; 01 marks a load
MemWriteM  input  1  store
funct3M  input  3  access size/sign
ALUResultM  input  word_width  effective address / ALU result
WriteDataM  input  word_width  store data (unaligned, lane 0)
RdM  input  5  destination register
PCPlus4M  input  word_width  PC+4
StallM  output  1  M instruction not complete; upstream holds all M inputs stable
access_err  output  1  one-cycle pulse: misaligned or illegal funct3 access
dmem_req  output  1  request valid
dmem_we  output  1  1 store, 0 load
dmem_addr  output  word_width  {ALUResultM[31:2],2'b00}
dmem_wdata  output  word_width  lane-replicated store data
dmem_be  output  4  byte enables
dmem_gnt  input  1  request accepted this cycle
dmem_rvalid  input  1  load data valid
dmem_rdata  input  word_width  load word
RegWriteW  output  1  registered
ResultSrcW  output  2  registered
ReadDataW  output  word_width  registered, extended load data
ALUResultW  output  word_width  registered
RdW  output  5  registered
PCPlus4W  output  word_width  registered

Behaviour:
- access = MemWriteM | (ResultSrcM==2'b01). If both are set, the store takes priority.
- Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal store funct3: 000 SB, 001 SH, 010 SW.
- Alignment: halfword requires addr[0]==0; word requires addr[1:0]==0.
- Illegal or misaligned access: no dmem_req; access_err=1 for one cycle; the instruction completes as a bubble (RegWriteW=0); StallM=0.
- Store formatting:
  - SB: be=0001<<addr[1:0], wdata={4{WriteDataM[7:0]}}
  - SH: be=0011<<{addr[1],1'b0}, wdata={2{WriteDataM[15:0]}}
  - SW: be=1111, wdata=WriteDataM
  - Loads drive be=1111, wdata=0.
- FSM states: IDLE, WAIT_RESP.
- IDLE:
  - dmem_req = legal access (combinational).
  - Store with gnt: complete this cycle, stay IDLE.
  - Load with gnt: go to WAIT_RESP.
  - No gnt: remain IDLE with request held.
  - StallM = legal access & !(store & gnt) | (load & legal).
- WAIT_RESP:
  - dmem_req=0; StallM = !dmem_rvalid.
  - On rvalid: complete, return to IDLE.
  - The memory never returns rvalid in the same cycle as gnt.
  - Exactly one rvalid per load gnt; rvalid while in IDLE is ignored.
- W register update, every rising clk:
  - Completing cycle: W <= M bundle; ReadDataW <= extended data, else 0.
  - Non-access instruction: completes immediately (StallM=0), one-cycle latency M→W.
  - Stall cycle: RegWriteW <= 0 (bubble); all other W fields hold.
- Load extension: select byte/half by addr[1:0] from dmem_rdata (little-endian). LB/LH sign-extend; LBU/LHU zero-extend.
- Reset: all W outputs 0, FSM IDLE. Combinational outputs follow inputs: StallM, dmem_* and access_err are 0 when no access.
- Reset in WAIT_RESP: the outstanding load is abandoned and its late rvalid is ignored.
- Back-to-back accesses: a new request may issue in the cycle after completion.

Test Plan:
- ADD bubble-free: RegWriteM=1, ResultSrcM=00, ALUResultM=0x1234, RdM=5 -> next cycle RegWriteW=1, ALUResultW=0x1234, RdW=5; StallM never 1.
- SB addr=0x103, data=0xAB, gnt after 2 wait cycles -> dmem_be=1000, wdata=0xABABABAB, StallM=1 for 2 cycles then 0, RegWriteW=0 throughout.
- LB addr=0x101, gnt immediate, rvalid 3 cycles later with rdata=0x0080FF00 -> ReadDataW=0xFFFFFFFF.
- Same access as LBU -> ReadDataW=0x000000FF; LH addr=0x102 -> 0x00000080.
- LW addr=0x102 -> access_err pulse, dmem_req=0, StallM=0, RegWriteW=0 next cycle.
- Reset asserted in WAIT_RESP, rvalid arrives after reset release -> W stays 0, FSM IDLE, no stall.
